sr_latch_driver: RTL and testbench

Clocked sequencer that writes one bit into an external cross-coupled NAND set/reset latch with active-low `set_n`/`reset_n` inputs.
- Accepts a write request over a ready/request handshake and generates exactly one active-low set or reset pulse of fixed width.
- Guarantees the forbidden both-low input state never occurs, waits a settle interval, then optionally reads back the latch's `q`/`nq` and flags a mismatch.
- Sits between synchronous control logic and latch-based storage; it is the write side of the latch interface.

---
 rtl/sr_latch_pkg.sv | 14 +
 rtl/sr_latch_driver_sync2.sv | 21 ++
 rtl/sr_latch_driver.sv | 132 +++++++++++++
 tb/tb_sr_latch_driver.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sr_latch_pkg.sv
// Shared types and default constants for the SR latch write driver.
package sr_latch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } srl_state_e;

  localparam int SRL_PULSE_W_DEF  = 2;
  localparam int SRL_SETTLE_W_DEF = 3;

endpackage

// File: rtl/sr_latch_driver_sync2.sv
// 1-bit two-flop synchronizer with synchronous active-high reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sr_latch_driver.sv
// Write sequencer for an external NAND set/reset latch: one fixed-width active-low pulse,
// settle interval, then optional readback when SR_LATCH_DRIVER_READBACK_EN is defined.
module sr_latch_driver
  import sr_latch_pkg::*;
#(
  parameter int PULSE_W  = SRL_PULSE_W_DEF,
  parameter int SETTLE_W = SRL_SETTLE_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic data,
  output logic rdy,
  output logic set_n,
  output logic reset_n,
  input  logic q,
  input  logic nq,
  output logic done,
  output logic err,
  output logic q_out
);

  localparam int MAX_W = (PULSE_W > SETTLE_W) ? PULSE_W : SETTLE_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  srl_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             data_r, data_nxt;
  logic             accept, mismatch;
  logic             rdy_nxt, set_n_nxt, reset_n_nxt, done_nxt, err_nxt, q_out_nxt;

`ifdef SR_LATCH_DRIVER_READBACK_EN
  logic q_s, nq_s;

  if (SETTLE_W < 3) begin : g_bad_settle
    $error("sr_latch_driver: SETTLE_W must be >= 3 with readback enabled");
  end

  sync2 u_sync_q  (.clk(clk), .rst(rst), .d(q),  .q(q_s));
  sync2 u_sync_nq (.clk(clk), .rst(rst), .d(nq), .q(nq_s));

  assign mismatch = (q_s != data_r) | (nq_s != ~data_r);
`else
  logic unused_readback;
  assign unused_readback = q ^ nq;
  assign mismatch        = 1'b0;
`endif

  // rdy is only ever high while in IDLE, so it alone qualifies acceptance.
  assign accept = rdy & req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      data_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      data_r <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data_r;
    done_nxt  = 1'b0;
    err_nxt   = err;
    q_out_nxt = q_out;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = PULSE;
          cnt_nxt   = CNT_W'(PULSE_W - 1);
          data_nxt  = data;
          err_nxt   = 1'b0;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_nxt = SETTLE;
          cnt_nxt   = CNT_W'(SETTLE_W - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_nxt = CHECK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      CHECK: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        done_nxt  = 1'b1;
        q_out_nxt = data_r;
        err_nxt   = mismatch;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Line drives decode the current state, so each line sits one cycle behind the FSM.
    rdy_nxt     = (state == IDLE) && !accept;
    set_n_nxt   = !((state == PULSE) && data_r);
    reset_n_nxt = !((state == PULSE) && !data_r);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy     <= 1'b1;
      set_n   <= 1'b1;
      reset_n <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
      q_out   <= 1'b0;
    end else begin
      rdy     <= rdy_nxt;
      set_n   <= set_n_nxt;
      reset_n <= reset_n_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      q_out   <= q_out_nxt;
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver driving a behavioural NAND SR latch; honours
// SR_LATCH_DRIVER_READBACK_EN for the expected err value.
module tb_sr_latch_driver;

`ifdef SR_LATCH_DRIVER_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic clk = 1'b0;
  logic rst, req, data;
  logic rdy, set_n, reset_n, done, err, q_out;
  logic q, nq;
  logic latch_q = 1'b0;
  logic force_rb = 1'b0;
  logic mon_en = 1'b0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sr_latch_driver dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .rdy(rdy),
    .set_n(set_n), .reset_n(reset_n), .q(q), .nq(nq),
    .done(done), .err(err), .q_out(q_out)
  );

  always @(set_n or reset_n) begin
    if (!set_n && reset_n)      latch_q = 1'b1;
    else if (set_n && !reset_n) latch_q = 1'b0;
  end
  assign q  = force_rb ? 1'b0 : latch_q;
  assign nq = force_rb ? 1'b1 : ~latch_q;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  always @(negedge clk)
    if (mon_en) check("never_both_low", int'(!set_n && !reset_n), 0);

  task automatic do_write(input logic d, input int exp_err);
    int set_lo = 0, rst_lo = 0, done_cnt = 0, done_at = -1;
    @(negedge clk);
    check("rdy_before_req", int'(rdy), 1);
    req = 1'b1; data = d;
    @(negedge clk);
    req = 1'b0;
    check("rdy_drops", int'(rdy), 0);
    check("err_clear_on_accept", int'(err), 0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (!set_n)   set_lo++;
      if (!reset_n) rst_lo++;
      if (done) begin
        done_cnt++;
        done_at = k;
        check("err_at_done", int'(err), exp_err);
        check("q_out_at_done", int'(q_out), int'(d));
        if (!force_rb) begin
          check("latch_q", int'(q), int'(d));
          check("latch_nq", int'(nq), int'(!d));
        end
      end
      if (k == 7) check("rdy_after_done", int'(rdy), 1);
    end
    check("set_n_low_cycles", set_lo, d ? 2 : 0);
    check("reset_n_low_cycles", rst_lo, d ? 0 : 2);
    check("done_count", done_cnt, 1);
    check("done_latency", done_at, 6);
  endtask

  initial begin
    int starts, first_at, second_at, done_cnt, rst_lo;
    logic prev_set_n;
    rst = 1'b1; req = 1'b0; data = 1'b0;

    @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_set_n", int'(set_n), 1);
    check("rst_reset_n", int'(reset_n), 1);
    check("rst_rdy", int'(rdy), 1);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_q_out", int'(q_out), 0);
    rst = 1'b0;

    do_write(1'b1, 0);
    do_write(1'b0, 0);

    // req held across two operations: accepts at edges 0 and 8 only
    @(negedge clk);
    req = 1'b1; data = 1'b1;
    starts = 0; first_at = -1; second_at = -1; done_cnt = 0; rst_lo = 0;
    prev_set_n = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 14) req = 1'b0;
      if (!set_n && prev_set_n) begin
        starts++;
        if (starts == 1) first_at = n;
        if (starts == 2) second_at = n;
      end
      if (!reset_n) rst_lo++;
      if (done) done_cnt++;
      prev_set_n = set_n;
    end
    check("held_req_pulses", starts, 2);
    check("held_req_spacing", second_at - first_at, 8);
    check("held_req_dones", done_cnt, 2);
    check("held_req_reset_n_idle", rst_lo, 0);

    force_rb = 1'b1;
    do_write(1'b1, RB);
    force_rb = 1'b0;
    check("err_holds_after_done", int'(err), RB);
    do_write(1'b1, 0);

    // reset during the second PULSE cycle truncates the pulse
    @(negedge clk);
    req = 1'b1; data = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("mid_pulse_set_n_low", int'(set_n), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_set_n", int'(set_n), 1);
    check("mid_rst_rdy", int'(rdy), 1);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_q_out", int'(q_out), 0);
    done_cnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("no_done_after_rst", done_cnt, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
